// File: rtl/prv32_mdu_pkg.sv
// Shared types for the PRV32 divide unit: op encodings, FSM states, widths and
// small sign helpers used by the top-level datapath.
package prv32_mdu_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    MDU_DIV  = 2'b00,
    MDU_DIVU = 2'b01,
    MDU_REM  = 2'b10,
    MDU_REMU = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } mdu_state_e;

  function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic en);
    return en ? (~v + 1'b1) : v;
  endfunction

  function automatic logic is_rem_op(input mdu_op_e op);
    return (op == MDU_REM) || (op == MDU_REMU);
  endfunction

  function automatic logic is_signed_op(input mdu_op_e op);
    return (op == MDU_DIV) || (op == MDU_REM);
  endfunction

endpackage

// File: rtl/prv32_div_step.sv
// One radix-2 restoring division iteration: shift remainder:dividend left,
// trial-subtract the divisor, keep the difference and shift in a 1 if no borrow.
module prv32_div_step
  import prv32_mdu_pkg::*;
#(
  parameter int W = XLEN
) (
  input  logic [W-1:0] rem_i,
  input  logic [W-1:0] dvd_i,
  input  logic [W-1:0] dvs_i,
  output logic [W-1:0] rem_o,
  output logic [W-1:0] dvd_o
);

  logic [W:0] shifted;
  logic [W:0] trial;
  logic       borrow;

  always_comb begin
    shifted = {rem_i, dvd_i[W-1]};
    trial   = shifted - {1'b0, dvs_i};
    borrow  = trial[W];
    rem_o   = borrow ? shifted[W-1:0] : trial[W-1:0];
    dvd_o   = {dvd_i[W-2:0], ~borrow};
  end

endmodule

// File: rtl/prv32_mdu.sv
// PRV32 iterative divider (DIV/DIVU/REM/REMU), 32 restoring steps per op.
// Optional PRV32_MDU_EARLY_OUT_EN skips CALC for divide-by-zero and signed overflow.
module prv32_mdu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  input  logic            flush,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_result,
  output logic            busy
);
  import prv32_mdu_pkg::*;

  mdu_state_e             state_q, state_d;
  mdu_op_e                op_q, op_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [XLEN-1:0]        rem_q, rem_d;
  logic [XLEN-1:0]        dvd_q, dvd_d;
  logic [XLEN-1:0]        dvs_q, dvs_d;
  logic [XLEN-1:0]        result_q, result_d;
  logic                   q_neg_q, q_neg_d;
  logic                   r_neg_q, r_neg_d;
  logic                   div0_q, div0_d;

  mdu_op_e                req_op_e;
  logic                   a_neg, b_neg;
  logic [XLEN-1:0]        step_rem, step_dvd;
`ifdef PRV32_MDU_EARLY_OUT_EN
  logic                   special;
  logic [XLEN-1:0]        special_result;
`endif

  prv32_div_step #(.W(XLEN)) u_step (
    .rem_i (rem_q),
    .dvd_i (dvd_q),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .dvd_o (step_dvd)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    result_d = result_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    div0_d   = div0_q;

    req_op_e = mdu_op_e'(req_op);
    a_neg    = is_signed_op(req_op_e) & req_a[XLEN-1];
    b_neg    = is_signed_op(req_op_e) & req_b[XLEN-1];
`ifdef PRV32_MDU_EARLY_OUT_EN
    // Overflow: quotient equals the dividend, remainder is zero.
    special        = (req_b == '0) ||
                     (is_signed_op(req_op_e) && req_a == {1'b1, {(XLEN-1){1'b0}}} && req_b == '1);
    special_result = is_rem_op(req_op_e) ? ((req_b == '0) ? req_a : '0)
                                         : ((req_b == '0) ? '1 : req_a);
`endif

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_d    = req_op_e;
          dvd_d   = neg_if(req_a, a_neg);
          dvs_d   = neg_if(req_b, b_neg);
          rem_d   = '0;
          cnt_d   = '0;
          q_neg_d = a_neg ^ b_neg;
          r_neg_d = a_neg;
          div0_d  = (req_b == '0);
          state_d = ST_CALC;
`ifdef PRV32_MDU_EARLY_OUT_EN
          if (special) begin
            result_d = special_result;
            state_d  = ST_DONE;
          end
`endif
        end
      end
      ST_CALC: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          rem_d = step_rem;
          dvd_d = step_dvd;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(XLEN-1)) begin
            // Restoring division by zero leaves |a| as remainder; only the quotient needs forcing.
            result_d = is_rem_op(op_q) ? neg_if(step_rem, r_neg_q)
                                       : (div0_q ? '1 : neg_if(step_dvd, q_neg_q));
            state_d  = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (flush || rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= MDU_DIV;
      cnt_q    <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      result_q <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      div0_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      result_q <= result_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      div0_q   <= div0_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign rsp_valid  = (state_q == ST_DONE);
  assign busy       = (state_q != ST_IDLE);
  assign rsp_result = rsp_valid ? result_q : '0;

endmodule
